// File: rtl/oa21_sweep_ctrl.sv
// oa21_sweep_ctrl: sequencer and self-checker for a single oa21 cell (Y = ~((A|B)&C)).
// A start pulse drives all eight {a,b,c} vectors in order. Each vector is held for
// SETTLE_CYCLES cycles plus one check cycle. The cell output y is compared against
// the golden function, and the mismatch count and first failing vector are reported.
//
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   start      begin a sweep (accepted in IDLE or DONE)
//   abort      cancel a sweep in progress
//   y          output of the oa21 cell under control
//   a, b, c    registered drives to the cell inputs
//   busy       sweep in progress
//   done       sweep complete; held until the next start or reset
//   pass       done with no mismatches
//   err_count  number of mismatching vectors, 0..8
//   fail_vec   {a,b,c} of the first mismatch, 0 if none
module oa21_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] fail_vec
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t           state, state_n;
  logic [2:0]       idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             busy_n, done_n;
  logic [3:0]       err_n;
  logic [2:0]       fail_n;
  logic             exp_y;
  logic             mismatch;

  // The vector index is the cell drive, so a/b/c come straight from a register.
  assign a = idx[2];
  assign b = idx[1];
  assign c = idx[0];

  assign pass = done && (err_count == 4'd0);

  // Golden oa21 value. The 4-state compare treats x or z on y as a failure.
  always_comb begin
    exp_y    = ~((idx[2] | idx[1]) & idx[0]);
    mismatch = (y !== exp_y);
  end

  // State register and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 3'd0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= 4'd0;
      fail_vec  <= 3'd0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      busy      <= busy_n;
      done      <= done_n;
      err_count <= err_n;
      fail_vec  <= fail_n;
    end
  end

  // Next-state and next-value logic.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    busy_n  = busy;
    done_n  = done;
    err_n   = err_count;
    fail_n  = fail_vec;

    case (state)
      IDLE, DONE: begin
        // Start also takes priority over abort here.
        if (start) begin
          state_n = SETTLE;
          idx_n   = 3'd0;
          cnt_n   = SETTLE_LD;
          err_n   = 4'd0;
          fail_n  = 3'd0;
          done_n  = 1'b0;
          busy_n  = 1'b1;
        end
      end

      SETTLE: begin
        if (abort) begin
          state_n = IDLE;
          idx_n   = 3'd0;
          cnt_n   = '0;
          busy_n  = 1'b0;
          done_n  = 1'b0;
        end else begin
          cnt_n = cnt - CNT_ONE;
          if (cnt == CNT_ONE) state_n = CHECK;
        end
      end

      CHECK: begin
        // An abort here discards this vector's result.
        if (abort) begin
          state_n = IDLE;
          idx_n   = 3'd0;
          cnt_n   = '0;
          busy_n  = 1'b0;
          done_n  = 1'b0;
        end else begin
          if (mismatch) begin
            err_n = err_count + 4'd1;
            if (err_count == 4'd0) fail_n = idx;
          end
          if (idx != 3'd7) begin
            idx_n   = idx + 3'd1;
            cnt_n   = SETTLE_LD;
            state_n = SETTLE;
          end else begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/oa21_sweep_ctrl.md
Name: oa21_sweep_ctrl

Overview:
- Sequencer and self-checker for one oa21 cell, whose function is Y = ~((A|B)&C).
- On a start pulse it drives all 8 {A,B,C} vectors into the cell in order and waits a programmable settle time per vector.
- It samples Y and compares it against the golden function.
- It reports pass/fail, a mismatch count and the first failing vector.
- Used in cell characterisation benches and as a built-in check wrapper around the gate-level oa21 instance.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before Y is sampled. Legal range 1..15.
- CNT_W, 4, width of the settle counter. Must hold SETTLE_CYCLES.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a sweep; sampled in IDLE or DONE only
- abort  input  1  cancel a sweep in progress
- y  input  1  output of the oa21 cell under control
- a  output  1  drive to cell input A (registered)
- b  output  1  drive to cell input B (registered)
- c  output  1  drive to cell input C (registered)
- busy  output  1  high while a sweep is in progress
- done  output  1  sweep complete; held until the next start or reset
- pass  output  1  done && err_count==0
- err_count  output  4  number of mismatching vectors, 0..8
- fail_vec  output  3  {a,b,c} of the first mismatch; 0 if none

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE.
  - a, b, c, busy, done, pass, err_count, fail_vec all 0.
  - Vector index and settle counter are 0.
  - Reset asserted mid-sweep aborts it immediately; no partial result is retained.
- Vector order: idx 0..7, with {a,b,c} = idx (a=idx[2], c=idx[0]).
- Expected value: exp = ~((a|b)&c). Vectors 011, 101 and 111 expect 0; all others expect 1.
- States:
  - IDLE: busy=0. start=1 at an edge → SETTLE. At that edge: idx←0, {a,b,c}←000, cnt←SETTLE_CYCLES, err_count←0, fail_vec←0, done←0, busy←1.
  - SETTLE: cnt decrements each edge. When cnt==1 → CHECK.
  - CHECK (one cycle): compare y against exp for the current {a,b,c}.
    - A mismatch is y!==exp; x or z on y counts as a mismatch.
    - On mismatch: err_count increments, and fail_vec←{a,b,c} if err_count was 0.
    - If idx<7: idx increments, {a,b,c}←idx+1, cnt←SETTLE_CYCLES, → SETTLE.
    - If idx==7: → DONE with busy←0 and done←1. Inputs a, b, c stay at 111.
  - DONE: done=1 and results are held. start=1 → restart exactly as from IDLE, clearing results in the same edge.
- Timing:
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - done rises 8*(SETTLE_CYCLES+1) edges after the start edge: 24 at default, 16 for SETTLE_CYCLES=1.
- pass is combinational from done and err_count. pass=0 whenever done=0.
- start while busy=1 is ignored.
- abort=1 in SETTLE or CHECK:
  - → IDLE at the next edge: a, b, c←0, busy←0, done←0.
  - err_count and fail_vec keep their partial values.
  - Abort has priority over a CHECK update in the same cycle; that vector is not counted.
  - abort in IDLE or DONE has no effect.
- Simultaneous start and abort in IDLE/DONE: start wins.
- err_count never exceeds 8, so no saturation logic is needed.

Test Plan:
- Correct oa21 model on y, SETTLE_CYCLES=2, start for 1 cycle:
  - busy high for 24 cycles, then done=1, pass=1, err_count=0, fail_vec=000.
  - a/b/c step 000→111, changing every 3 cycles.
- y tied 0:
  - done after 24 cycles, err_count=5, fail_vec=000, pass=0.
- y tied 1:
  - err_count=3, fail_vec=011, pass=0.
- y driven x:
  - err_count=8, fail_vec=000.
- Behaviour checks with the correct model:
  - start pulsed again at cycle 5 → ignored; done still at cycle 24.
  - Restart from DONE clears done and err_count on the start edge.
- Mid-sweep cancellation:
  - rst asserted at cycle 10 → all outputs 0 immediately, state IDLE.
  - abort at cycle 10 → next edge busy=0, done=0, abc=000, then idle.
  - SETTLE_CYCLES=1 build: done at cycle 16.
